// File: rtl/pic_core_pkg.sv
// Shared constants, STKSTAT bit positions and FSM state type for the
// return-stack sequencer of the single-cycle core.
package pic_core_pkg;

    localparam int              AW         = 11;
    localparam int              DEPTH      = 16;
    localparam int              DW         = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]   INT_VECTOR = 11'h004;
    localparam int              RST_PULSE  = 4;
    localparam int              CW         = $clog2(RST_PULSE);

    localparam int              STKOVF_BIT = 7;
    localparam int              STKUNF_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INT_PUSH,
        ST_INT_VEC,
        ST_FAULT
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Return-stack sequencer: turns call/return/interrupt requests into push/pop
// strobes, tracks occupancy, raises sticky overflow/underflow flags and faults.
module stack_ctrl
    import pic_core_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic          int_req,
    input  logic [AW-1:0] pc_ret,
    input  logic          stvren,
    input  logic [AW-1:0] stack_out,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] stack_in,
    output logic [AW-1:0] ret_addr,
    output logic          vec_load,
    output logic [AW-1:0] vec_addr,
    output logic          stall,
    output logic          reset_req,
    input  logic          sfr_we,
    input  logic [7:0]    sfr_wdata,
    output logic [7:0]    sfr_rdata
);

    state_e         r_state;
    logic [DW-1:0]  r_depth;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf;
    logic           r_unf;

    logic w_idle, w_call, w_ret, w_full, w_empty;
    logic w_push, w_pop, w_ovf_set, w_unf_set, w_fault;
    logic w_ovf_clr, w_unf_clr;
    logic w_unused_wdata;

    // Request priority in IDLE: interrupt, then call, then return.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_call    = w_idle & ~int_req & call_req;
    assign w_ret     = w_idle & ~int_req & ~call_req & ret_req;
    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_empty   = (r_depth == '0);

    // Overflowing pushes still reach Stack, which wraps onto its oldest entry.
    assign w_push    = w_call | (r_state == ST_INT_PUSH);
    assign w_pop     = w_ret & ~w_empty;
    assign w_ovf_set = w_push & w_full;
    assign w_unf_set = w_ret & w_empty;
    assign w_fault   = (w_ovf_set | w_unf_set) & stvren;

    assign w_ovf_clr = sfr_we & ~sfr_wdata[STKOVF_BIT];
    assign w_unf_clr = sfr_we & ~sfr_wdata[STKUNF_BIT];
    assign w_unused_wdata = &{1'b0, sfr_wdata[5:0]};

    assign push      = w_push;
    assign pop       = w_pop;
    assign stack_in  = pc_ret;
    assign ret_addr  = w_unf_set ? '0 : stack_out;
    assign vec_load  = (r_state == ST_INT_VEC);
    assign vec_addr  = INT_VECTOR;
    assign stall     = ~w_idle;
    assign reset_req = (r_state == ST_FAULT);
    assign sfr_rdata = {r_ovf, r_unf, 1'b0, r_depth};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (w_fault) begin
            r_state <= ST_FAULT;
            r_cnt   <= CW'(RST_PULSE - 1);
        end else begin
            case (r_state)
                ST_IDLE:     if (int_req) r_state <= ST_INT_PUSH;
                ST_INT_PUSH: r_state <= ST_INT_VEC;
                ST_INT_VEC:  r_state <= ST_IDLE;
                ST_FAULT: begin
                    if (r_cnt == '0) r_state <= ST_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth <= '0;
        end else if (w_push && !w_full) begin
            r_depth <= r_depth + 1'b1;
        end else if (w_pop) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // A flag set in the same cycle as a software clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            r_unf <= w_unf_set | (r_unf & ~w_unf_clr);
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 16-entry wrapping Stack
// feeding stack_out back to the controller.
module tb_stack_ctrl;
    import pic_core_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          call_req = 1'b0, ret_req = 1'b0, int_req = 1'b0;
    logic [AW-1:0] pc_ret = '0;
    logic          stvren = 1'b0;
    logic [AW-1:0] stack_out;
    logic          push, pop, vec_load, stall, reset_req;
    logic [AW-1:0] stack_in, ret_addr, vec_addr;
    logic          sfr_we = 1'b0;
    logic [7:0]    sfr_wdata = '0;
    logic [7:0]    sfr_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .int_req(int_req), .pc_ret(pc_ret), .stvren(stvren),
        .stack_out(stack_out), .push(push), .pop(pop), .stack_in(stack_in),
        .ret_addr(ret_addr), .vec_load(vec_load), .vec_addr(vec_addr),
        .stall(stall), .reset_req(reset_req), .sfr_we(sfr_we),
        .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata)
    );

    // Stack model: own wrapping pointer, TOS at sp-1.
    logic [AW-1:0] mem [16];
    logic [3:0]    sp;
    always @(posedge clk or posedge rst) begin
        if (rst) sp <= '0;
        else if (push) begin
            mem[sp] <= stack_in;
            sp      <= sp + 4'd1;
        end else if (pop) sp <= sp - 4'd1;
    end
    assign stack_out = mem[sp - 4'd1];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic c, input logic r, input logic i,
                         input logic [AW-1:0] pc, input logic we, input logic [7:0] wd);
        @(negedge clk);
        call_req  = c;
        ret_req   = r;
        int_req   = i;
        pc_ret    = pc;
        sfr_we    = we;
        sfr_wdata = wd;
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_push", 16'(push), 16'h0);
        check("rst_pop", 16'(pop), 16'h0);
        check("rst_vec_load", 16'(vec_load), 16'h0);
        check("rst_stall", 16'(stall), 16'h0);
        check("rst_reset_req", 16'(reset_req), 16'h0);
        check("rst_sfr", 16'(sfr_rdata), 16'h00);
        @(negedge clk);
        rst = 1'b0;

        // 1: three calls then three returns
        drive(1, 0, 0, 11'h010, 0, 8'h00);
        check("t1_push0", 16'(push), 16'h1);
        check("t1_stack_in0", 16'(stack_in), 16'h010);
        check("t1_pop0", 16'(pop), 16'h0);
        drive(1, 0, 0, 11'h020, 0, 8'h00);
        check("t1_push1", 16'(push), 16'h1);
        drive(1, 0, 0, 11'h030, 0, 8'h00);
        check("t1_push2", 16'(push), 16'h1);
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t1_depth3", 16'(sfr_rdata), 16'h03);
        check("t1_pop_a", 16'(pop), 16'h1);
        check("t1_ret_a", 16'(ret_addr), 16'h030);
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t1_ret_b", 16'(ret_addr), 16'h020);
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t1_ret_c", 16'(ret_addr), 16'h010);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t1_depth0", 16'(sfr_rdata), 16'h00);

        // 2: interrupt entry
        drive(0, 0, 1, 11'h155, 0, 8'h00);
        check("t2_c0_push", 16'(push), 16'h0);
        check("t2_c0_stall", 16'(stall), 16'h0);
        drive(0, 0, 0, 11'h155, 0, 8'h00);
        check("t2_c1_push", 16'(push), 16'h1);
        check("t2_c1_stack_in", 16'(stack_in), 16'h155);
        check("t2_c1_stall", 16'(stall), 16'h1);
        check("t2_c1_vec_load", 16'(vec_load), 16'h0);
        drive(0, 0, 0, 11'h155, 0, 8'h00);
        check("t2_c2_vec_load", 16'(vec_load), 16'h1);
        check("t2_c2_vec_addr", 16'(vec_addr), 16'h004);
        check("t2_c2_stall", 16'(stall), 16'h1);
        check("t2_c2_push", 16'(push), 16'h0);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t2_c3_stall", 16'(stall), 16'h0);
        check("t2_c3_vec_load", 16'(vec_load), 16'h0);
        check("t2_depth1", 16'(sfr_rdata), 16'h01);
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t2_ret", 16'(ret_addr), 16'h155);
        check("t2_pop", 16'(pop), 16'h1);

        // 6a: call and return together -> push only
        drive(1, 1, 0, 11'h077, 0, 8'h00);
        check("t6_cr_push", 16'(push), 16'h1);
        check("t6_cr_pop", 16'(pop), 16'h0);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t6_cr_depth", 16'(sfr_rdata), 16'h01);
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t6_cr_ret", 16'(ret_addr), 16'h077);

        // 6b: interrupt with call -> interrupt sequence only
        drive(1, 0, 1, 11'h0AA, 0, 8'h00);
        check("t6_ic_push0", 16'(push), 16'h0);
        drive(0, 0, 0, 11'h0AA, 0, 8'h00);
        check("t6_ic_push1", 16'(push), 16'h1);
        check("t6_ic_stack_in", 16'(stack_in), 16'h0AA);
        drive(0, 0, 0, 11'h0AA, 0, 8'h00);
        check("t6_ic_vec_load", 16'(vec_load), 16'h1);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t6_ic_depth", 16'(sfr_rdata), 16'h01);
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t6_ic_ret", 16'(ret_addr), 16'h0AA);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t6_ic_depth0", 16'(sfr_rdata), 16'h00);

        // 3: seventeen calls with stvren=0
        for (int i = 1; i <= 16; i++) drive(1, 0, 0, AW'(i), 0, 8'h00);
        drive(1, 0, 0, 11'h111, 0, 8'h00);
        check("t3_depth16", 16'(sfr_rdata), 16'h10);
        check("t3_push17", 16'(push), 16'h1);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t3_ovf", 16'(sfr_rdata), 16'h90);
        check("t3_reset_req", 16'(reset_req), 16'h0);
        check("t3_stall", 16'(stall), 16'h0);

        // 5: flag clearing
        drive(0, 0, 0, 11'h000, 1, 8'hFF);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t5_write1_noeffect", 16'(sfr_rdata), 16'h90);
        drive(0, 0, 0, 11'h000, 1, 8'h00);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t5_clear", 16'(sfr_rdata), 16'h10);
        drive(1, 0, 0, 11'h222, 1, 8'h00);
        check("t5_ovf_push", 16'(push), 16'h1);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t5_set_wins", 16'(sfr_rdata), 16'h90);
        drive(0, 0, 0, 11'h000, 1, 8'h00);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t5_clear2", 16'(sfr_rdata), 16'h10);

        // Drain to empty
        for (int i = 0; i < 16; i++) drive(0, 1, 0, 11'h000, 0, 8'h00);
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("drain_depth0", 16'(sfr_rdata), 16'h00);

        // 4: underflow with stvren=1
        stvren = 1'b1;
        drive(0, 1, 0, 11'h000, 0, 8'h00);
        check("t4_pop", 16'(pop), 16'h0);
        check("t4_ret_addr", 16'(ret_addr), 16'h000);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 11'h333, 0, 8'h00);
            check($sformatf("t4_reset_req%0d", i), 16'(reset_req), 16'h1);
            check($sformatf("t4_stall%0d", i), 16'(stall), 16'h1);
            check($sformatf("t4_push_ignored%0d", i), 16'(push), 16'h0);
            check($sformatf("t4_sfr%0d", i), 16'(sfr_rdata), 16'h40);
        end
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t4_reset_req_end", 16'(reset_req), 16'h0);
        check("t4_stall_end", 16'(stall), 16'h0);
        check("t4_sfr_end", 16'(sfr_rdata), 16'h40);
        stvren = 1'b0;

        // 6c: asynchronous reset in the middle of INT_PUSH
        drive(0, 0, 1, 11'h1AB, 0, 8'h00);
        drive(0, 0, 0, 11'h1AB, 0, 8'h00);
        check("t6_rst_pre_push", 16'(push), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_push", 16'(push), 16'h0);
        check("t6_rst_stall", 16'(stall), 16'h0);
        check("t6_rst_vec_load", 16'(vec_load), 16'h0);
        check("t6_rst_reset_req", 16'(reset_req), 16'h0);
        check("t6_rst_sfr", 16'(sfr_rdata), 16'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 11'h000, 0, 8'h00);
        check("t6_post_stall", 16'(stall), 16'h0);
        check("t6_post_vec_load", 16'(vec_load), 16'h0);
        check("t6_post_sfr", 16'(sfr_rdata), 16'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
